// File: rtl/fp32_serial_host.sv
// Host side of the fp32 adder's bit-serial link: serialises A then B, pulses go,
// waits for done, shifts the result back in and offers it on a valid/ready port.
module fp32_serial_host #(
   parameter int unsigned WIDTH     = 32,
   parameter bit          MSB_FIRST = 1'b1,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_sub,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_timeout,
   output logic             ser_data,
   output logic             ld_a,
   output logic             ld_b,
   output logic             ope,
   output logic             go,
   input  logic             done,
   output logic             shc,
   input  logic             ser_in
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int unsigned SW = 2 * WIDTH;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] SEND_A = 3'd1;
   localparam logic [2:0] SEND_B = 3'd2;
   localparam logic [2:0] START  = 3'd3;
   localparam logic [2:0] WAIT   = 3'd4;
   localparam logic [2:0] RECV   = 3'd5;
   localparam logic [2:0] RESP   = 3'd6;

   logic [2:0]       state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [TW-1:0]    timer, timer_nxt;
   logic [SW-1:0]    sh, sh_nxt;
   logic             ser_data_nxt;
   logic             ope_nxt;
   logic             rsp_timeout_nxt;
   logic [WIDTH-1:0] rsp_data_nxt;
   logic             cnt_last;

   assign cnt_last = (cnt == CNT_LAST);

   // Next-state and next-register values; ser_data leads the shift register by one bit.
   always_comb begin
      state_nxt       = state;
      cnt_nxt         = cnt;
      timer_nxt       = timer;
      sh_nxt          = sh;
      ser_data_nxt    = 1'b0;
      ope_nxt         = ope;
      rsp_data_nxt    = rsp_data;
      rsp_timeout_nxt = rsp_timeout;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_nxt = SEND_A;
               cnt_nxt   = '0;
               ope_nxt   = op_sub;
               if (MSB_FIRST) begin
                  sh_nxt       = {op_a[WIDTH-2:0], op_b, 1'b0};
                  ser_data_nxt = op_a[WIDTH-1];
               end else begin
                  sh_nxt       = {1'b0, op_b, op_a[WIDTH-1:1]};
                  ser_data_nxt = op_a[0];
               end
            end
         end
         SEND_A, SEND_B: begin
            if (MSB_FIRST) begin
               ser_data_nxt = sh[SW-1];
               sh_nxt       = {sh[SW-2:0], 1'b0};
            end else begin
               ser_data_nxt = sh[0];
               sh_nxt       = {1'b0, sh[SW-1:1]};
            end
            cnt_nxt = cnt_last ? '0 : cnt + CW'(1);
            if (cnt_last) begin
               state_nxt = (state == SEND_A) ? SEND_B : START;
            end
         end
         START: begin
            timer_nxt = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            timer_nxt = timer + TW'(1);
            if (done) begin
               state_nxt = RECV;
               cnt_nxt   = '0;
            end else if (timer == TMR_LAST) begin
               state_nxt       = RESP;
               rsp_data_nxt    = '0;
               rsp_timeout_nxt = 1'b1;
            end
         end
         RECV: begin
            if (MSB_FIRST) begin
               rsp_data_nxt = {rsp_data[WIDTH-2:0], ser_in};
            end else begin
               rsp_data_nxt = {ser_in, rsp_data[WIDTH-1:1]};
            end
            cnt_nxt = cnt_last ? '0 : cnt + CW'(1);
            if (cnt_last) begin
               state_nxt       = RESP;
               rsp_timeout_nxt = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_nxt       = IDLE;
               rsp_timeout_nxt = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and output registers; strobes are decoded from the next state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         timer       <= '0;
         sh          <= '0;
         ser_data    <= 1'b0;
         ope         <= 1'b0;
         rsp_data    <= '0;
         rsp_timeout <= 1'b0;
         rsp_valid   <= 1'b0;
         ld_a        <= 1'b0;
         ld_b        <= 1'b0;
         go          <= 1'b0;
         shc         <= 1'b0;
         req_ready   <= 1'b1;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         timer       <= timer_nxt;
         sh          <= sh_nxt;
         ser_data    <= ser_data_nxt;
         ope         <= ope_nxt;
         rsp_data    <= rsp_data_nxt;
         rsp_timeout <= rsp_timeout_nxt;
         rsp_valid   <= (state_nxt == RESP);
         ld_a        <= (state_nxt == SEND_A);
         ld_b        <= (state_nxt == SEND_B);
         go          <= (state_nxt == START);
         shc         <= (state_nxt == RECV);
         req_ready   <= (state_nxt == IDLE);
      end
   end

endmodule
